// File: rtl/combo_lock_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : combo_lock_sequencer
// Purpose : Captures three debounced {a,b} digit pairs, drives the display
//           write port, checks the code and enforces a timed lockout.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module combo_lock_sequencer #(
  parameter logic [7:0] CODE0          = 8'h28,
  parameter logic [7:0] CODE1          = 8'h19,
  parameter logic [7:0] CODE2          = 8'h96,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 50000000,
  parameter int         TMR_W          = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       enter,
  input  logic       clear,
  output logic       disp_we,
  output logic [1:0] disp_sel,
  output logic [7:0] disp_data,
  output logic       disp_clr,
  output logic [1:0] step,
  output logic       unlocked,
  output logic       error,
  output logic       locked_out,
  output logic [1:0] fail_count
);

  typedef enum logic [1:0] {
    S_ENTRY   = 2'd0,
    S_CHECK   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]       FAILS_MAX = 2'(MAX_FAILS);

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic             match_q, match_d;
  logic [1:0]       fail_q, fail_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             enter_q, clear_q;
  logic             we_q, we_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       data_q, data_d;
  logic             clr_q, clr_d;
  logic             error_q, error_d;
  logic             unlocked_q, locked_q;

  logic       press, clr_ev;
  logic [7:0] pair, code;
  logic [1:0] fail_inc;

  always_comb begin
    press    = enter & ~enter_q;
    clr_ev   = clear & ~clear_q;
    pair     = {a, b};
    fail_inc = (fail_q == FAILS_MAX) ? fail_q : fail_q + 2'd1;
    case (step_q)
      2'd0:    code = CODE0;
      2'd1:    code = CODE1;
      default: code = CODE2;
    endcase

    state_d = state_q;
    step_d  = step_q;
    match_d = match_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    we_d    = 1'b0;
    sel_d   = sel_q;
    data_d  = data_q;
    clr_d   = 1'b0;
    error_d = 1'b0;

    case (state_q)
      S_ENTRY: begin
        // An abort takes priority; a pair pressed in the same cycle is dropped.
        if (clr_ev) begin
          step_d  = 2'd0;
          match_d = 1'b1;
          clr_d   = 1'b1;
        end else if (press) begin
          we_d    = 1'b1;
          sel_d   = step_q;
          data_d  = pair;
          match_d = match_q & (pair == code);
          if (step_q == 2'd2) state_d = S_CHECK;
          else                step_d  = step_q + 2'd1;
        end
      end
      S_CHECK: begin
        step_d  = 2'd0;
        match_d = 1'b1;
        if (match_q) begin
          state_d = S_OPEN;
          fail_d  = 2'd0;
        end else begin
          error_d = 1'b1;
          fail_d  = fail_inc;
          if (fail_inc == FAILS_MAX) begin
            state_d = S_LOCKOUT;
            timer_d = TMR_LOAD;
          end else begin
            state_d = S_ENTRY;
            clr_d   = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (clr_ev) begin
          state_d = S_ENTRY;
          clr_d   = 1'b1;
        end
      end
      default: begin
        if (timer_q == '0) begin
          state_d = S_ENTRY;
          fail_d  = 2'd0;
          clr_d   = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_ENTRY;
      step_q     <= 2'd0;
      match_q    <= 1'b1;
      fail_q     <= 2'd0;
      timer_q    <= '0;
      enter_q    <= 1'b0;
      clear_q    <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 2'd0;
      data_q     <= 8'd0;
      clr_q      <= 1'b0;
      error_q    <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
      enter_q    <= enter;
      clear_q    <= clear;
      we_q       <= we_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      clr_q      <= clr_d;
      error_q    <= error_d;
      unlocked_q <= (state_d == S_OPEN);
      locked_q   <= (state_d == S_LOCKOUT);
    end
  end

  assign disp_we    = we_q;
  assign disp_sel   = sel_q;
  assign disp_data  = data_q;
  assign disp_clr   = clr_q;
  assign step       = step_q;
  assign unlocked   = unlocked_q;
  assign error      = error_q;
  assign locked_out = locked_q;
  assign fail_count = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_combo_lock_sequencer
// Purpose : Directed self-checking bench for combo_lock_sequencer.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_combo_lock_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic       enter = 1'b0, clear = 1'b0;
  logic       disp_we, disp_clr, unlocked, error, locked_out;
  logic [1:0] disp_sel, step, fail_count;
  logic [7:0] disp_data;

  int checks = 0;
  int errors = 0;

  combo_lock_sequencer #(.LOCKOUT_CYCLES(8), .TMR_W(4)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .enter(enter), .clear(clear),
    .disp_we(disp_we), .disp_sel(disp_sel), .disp_data(disp_data),
    .disp_clr(disp_clr), .step(step), .unlocked(unlocked), .error(error),
    .locked_out(locked_out), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  // Stimulus only: returns at the negedge where the press strobe is visible.
  task automatic enter_pair(input logic [3:0] da, input logic [3:0] db);
    @(negedge clock); a = da; b = db; enter = 1'b1;
    @(negedge clock); enter = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b0; enter = 1'b0; clear = 1'b0;
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic wrong_attempt();
    enter_pair(4'd2, 4'd8); enter_pair(4'd1, 4'd9); enter_pair(4'd9, 4'd7);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if ({disp_we, disp_clr, unlocked, error, locked_out} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {disp_we, disp_clr, unlocked, error, locked_out}); end
    checks++; if ({disp_sel, disp_data, step, fail_count} !== 14'd0) begin errors++; $display("FAIL reset_buses got %h want 0", {disp_sel, disp_data, step, fail_count}); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_correct_code();
    enter_pair(4'd2, 4'd8);
    checks++; if ({disp_we, disp_sel, disp_data} !== {1'b1, 2'd0, 8'h28}) begin errors++; $display("FAIL ok_strobe0 got %b/%0d/%h want 1/0/28", disp_we, disp_sel, disp_data); end
    checks++; if (step !== 2'd1) begin errors++; $display("FAIL ok_step1 got %0d want 1", step); end
    enter_pair(4'd1, 4'd9);
    checks++; if ({disp_we, disp_sel, disp_data} !== {1'b1, 2'd1, 8'h19}) begin errors++; $display("FAIL ok_strobe1 got %b/%0d/%h want 1/1/19", disp_we, disp_sel, disp_data); end
    enter_pair(4'd9, 4'd6);
    checks++; if ({disp_we, disp_sel, disp_data} !== {1'b1, 2'd2, 8'h96}) begin errors++; $display("FAIL ok_strobe2 got %b/%0d/%h want 1/2/96", disp_we, disp_sel, disp_data); end
    checks++; if (step !== 2'd2) begin errors++; $display("FAIL ok_step_check got %0d want 2", step); end
    @(negedge clock);
    checks++; if (disp_we !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL ok_after_check we=%b err=%b want 0/0", disp_we, error); end
    @(negedge clock);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL ok_unlocked got %b want 1", unlocked); end
    checks++; if (fail_count !== 2'd0 || step !== 2'd0) begin errors++; $display("FAIL ok_open_state fc=%0d step=%0d want 0/0", fail_count, step); end
    enter_pair(4'd3, 4'd3);
    checks++; if (disp_we !== 1'b0 || unlocked !== 1'b1) begin errors++; $display("FAIL ok_open_press we=%b unl=%b want 0/1", disp_we, unlocked); end
    pulse_clear();
    checks++; if ({disp_clr, unlocked, step} !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL ok_relock clr=%b unl=%b step=%0d want 1/0/0", disp_clr, unlocked, step); end
    @(negedge clock);
    checks++; if (disp_clr !== 1'b0) begin errors++; $display("FAIL ok_clr_once got %b want 0", disp_clr); end
  endtask

  task automatic test_wrong_code();
    do_reset();
    enter_pair(4'd2, 4'd8); enter_pair(4'd1, 4'd9); enter_pair(4'd9, 4'd7);
    checks++; if (disp_data !== 8'h97) begin errors++; $display("FAIL bad_data got %h want 97", disp_data); end
    @(negedge clock);
    checks++; if ({error, disp_clr, fail_count, step, unlocked} !== {1'b1, 1'b1, 2'd1, 2'd0, 1'b0}) begin errors++; $display("FAIL bad_check err=%b clr=%b fc=%0d step=%0d unl=%b want 1/1/1/0/0", error, disp_clr, fail_count, step, unlocked); end
    @(negedge clock);
    checks++; if ({error, unlocked, locked_out} !== 3'b000) begin errors++; $display("FAIL bad_pulse err=%b unl=%b lo=%b want 000", error, unlocked, locked_out); end
  endtask

  task automatic test_lockout();
    int cnt;
    do_reset();
    wrong_attempt();
    wrong_attempt();
    checks++; if (fail_count !== 2'd2 || locked_out !== 1'b0) begin errors++; $display("FAIL lo_pre fc=%0d lo=%b want 2/0", fail_count, locked_out); end
    enter_pair(4'd2, 4'd8); enter_pair(4'd1, 4'd9); enter_pair(4'd9, 4'd7);
    @(negedge clock);
    checks++; if ({error, disp_clr, fail_count} !== {1'b1, 1'b0, 2'd3}) begin errors++; $display("FAIL lo_entry err=%b clr=%b fc=%0d want 1/0/3", error, disp_clr, fail_count); end
    cnt = 0;
    while (locked_out === 1'b1 && cnt < 100) begin
      cnt++;
      if (disp_we !== 1'b0 || disp_clr !== 1'b0) begin checks++; errors++; $display("FAIL lo_quiet we=%b clr=%b want 0/0", disp_we, disp_clr); end
      case (cnt)
        2: begin a = 4'd2; b = 4'd8; enter = 1'b1; end
        3: enter = 1'b0;
        4: clear = 1'b1;
        5: clear = 1'b0;
        default: ;
      endcase
      @(negedge clock);
    end
    checks++; if (cnt !== 8) begin errors++; $display("FAIL lo_duration got %0d want 8", cnt); end
    checks++; if ({disp_clr, fail_count, step, disp_we} !== {1'b1, 2'd0, 2'd0, 1'b0}) begin errors++; $display("FAIL lo_exit clr=%b fc=%0d step=%0d we=%b want 1/0/0/0", disp_clr, fail_count, step, disp_we); end
    @(negedge clock);
    checks++; if (disp_clr !== 1'b0) begin errors++; $display("FAIL lo_clr_once got %b want 0", disp_clr); end
  endtask

  task automatic test_held_simultaneous();
    int we_cnt;
    do_reset();
    we_cnt = 0;
    @(negedge clock); a = 4'd2; b = 4'd8; enter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (disp_we === 1'b1) we_cnt++;
    end
    enter = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (disp_we === 1'b1) we_cnt++;
    end
    checks++; if (we_cnt !== 1 || step !== 2'd1) begin errors++; $display("FAIL held_single we_count=%0d step=%0d want 1/1", we_cnt, step); end
    @(negedge clock); a = 4'd1; b = 4'd9; enter = 1'b1; clear = 1'b1;
    @(negedge clock); enter = 1'b0; clear = 1'b0;
    checks++; if ({disp_clr, disp_we, step} !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL simul clr=%b we=%b step=%0d want 1/0/0", disp_clr, disp_we, step); end
  endtask

  task automatic test_abort_recover();
    do_reset();
    wrong_attempt();
    enter_pair(4'd2, 4'd8);
    pulse_clear();
    checks++; if ({disp_clr, step, fail_count} !== {1'b1, 2'd0, 2'd1}) begin errors++; $display("FAIL abort clr=%b step=%0d fc=%0d want 1/0/1", disp_clr, step, fail_count); end
    enter_pair(4'd2, 4'd8); enter_pair(4'd1, 4'd9); enter_pair(4'd9, 4'd6);
    @(negedge clock); @(negedge clock);
    checks++; if (unlocked !== 1'b1 || fail_count !== 2'd0) begin errors++; $display("FAIL recover unl=%b fc=%0d want 1/0", unlocked, fail_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wrong_attempt(); wrong_attempt(); wrong_attempt();
    repeat (2) @(negedge clock);
    checks++; if (locked_out !== 1'b1) begin errors++; $display("FAIL mid_lo_setup got %b want 1", locked_out); end
    reset = 1'b0;
    #1;
    checks++; if ({disp_we, disp_clr, unlocked, error, locked_out, step, fail_count} !== 9'd0) begin errors++; $display("FAIL mid_lo_reset got %b want 0", {disp_we, disp_clr, unlocked, error, locked_out, step, fail_count}); end
    @(negedge clock); reset = 1'b1;
    enter_pair(4'd2, 4'd8); enter_pair(4'd1, 4'd9);
    checks++; if (step !== 2'd2) begin errors++; $display("FAIL mid_entry_setup got %0d want 2", step); end
    reset = 1'b0;
    #1;
    checks++; if ({disp_we, disp_sel, disp_data, step, fail_count} !== 15'd0) begin errors++; $display("FAIL mid_entry_reset got %h want 0", {disp_we, disp_sel, disp_data, step, fail_count}); end
    @(negedge clock); reset = 1'b1;
    enter_pair(4'd2, 4'd8); enter_pair(4'd1, 4'd9); enter_pair(4'd9, 4'd6);
    @(negedge clock); @(negedge clock);
    checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL mid_reopen got %b want 1", unlocked); end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_held_simultaneous();
    test_abort_recover();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
